// File: rtl/sr_bank_pkg.sv
// Shared encodings for the set/reset register bank.
// Modes select the cell behaviour; policies pick the SR S=R=1 action.
package sr_bank_pkg;

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    localparam logic [1:0] POL_HOLD = 2'd0;
    localparam logic [1:0] POL_SET  = 2'd1;
    localparam logic [1:0] POL_RST  = 2'd2;
    localparam logic [1:0] POL_TGL  = 2'd3;

endpackage

// File: rtl/sr_cell.sv
// One storage cell's next-state logic.
// Purely combinational; the bank owns the flop.
module sr_cell
    import sr_bank_pkg::*;
(
    input  logic       q,
    input  logic       s,
    input  logic       r,
    input  logic [1:0] mode,
    input  logic [1:0] policy,
    output logic       q_next,
    output logic       illegal
);

    always_comb begin
        q_next  = q;
        illegal = 1'b0;
        unique case (mode)
            MODE_SR: begin
                illegal = s & r;
                unique case ({s, r})
                    2'b10: q_next = 1'b1;
                    2'b01: q_next = 1'b0;
                    2'b11: begin
                        unique case (policy)
                            POL_SET: q_next = 1'b1;
                            POL_RST: q_next = 1'b0;
                            POL_TGL: q_next = ~q;
                            default: q_next = q;
                        endcase
                    end
                    default: q_next = q;
                endcase
            end
            MODE_JK: begin
                unique case ({s, r})
                    2'b10: q_next = 1'b1;
                    2'b01: q_next = 1'b0;
                    2'b11: q_next = ~q;
                    default: q_next = q;
                endcase
            end
            MODE_D: q_next = s;
            default: q_next = s ? ~q : q;
        endcase
    end

endmodule

// File: rtl/sr_reg_bank.sv
// Bank of mode-selectable set/reset cells with sticky
// illegal-input flags and a saturating illegal-cycle counter.
module sr_reg_bank
    import sr_bank_pkg::*;
#(
    parameter int                WIDTH       = 8,
    parameter int                CNT_W       = 8,
    parameter int                SR11_POLICY = 0,
    parameter logic [WIDTH-1:0]  RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             clr_invalid,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    output logic [WIDTH-1:0] invalid,
    output logic [CNT_W-1:0] invalid_cnt
);

    localparam logic [1:0]       POLICY  = 2'(SR11_POLICY);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] cell_ill;
    logic [WIDTH-1:0] ill;
    logic             any_ill;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell u_cell (
            .q       (Q[i]),
            .s       (S[i]),
            .r       (R[i]),
            .mode    (mode),
            .policy  (POLICY),
            .q_next  (q_next[i]),
            .illegal (cell_ill[i])
        );
    end

    // Illegal detection only counts on cycles that actually update.
    assign ill     = en ? cell_ill : '0;
    assign any_ill = |ill;
    assign Q_bar   = ~Q;

    always_ff @(posedge clk) begin
        if (reset) begin
            Q           <= RESET_VAL;
            invalid     <= '0;
            invalid_cnt <= '0;
        end else begin
            if (en) begin
                Q <= q_next;
            end
            if (any_ill) begin
                if (clr_invalid) begin
                    invalid     <= ill;
                    invalid_cnt <= CNT_W'(1);
                end else begin
                    invalid <= invalid | ill;
                    if (invalid_cnt != CNT_MAX) begin
                        invalid_cnt <= invalid_cnt + CNT_W'(1);
                    end
                end
            end else if (clr_invalid) begin
                invalid     <= '0;
                invalid_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sr_reg_bank.sv
// Scoreboard bench: four banks, one per S=R=1 policy, share stimulus
// and are checked against a per-bit reference model.
module tb_sr_reg_bank;

    localparam logic [7:0] RV = 8'hA5;

    typedef struct {
        logic [7:0] q   [4];
        logic [7:0] inv [4];
        logic [1:0] cnt [4];
    } exp_t;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [7:0] s_in;
    logic [7:0] r_in;
    logic       clr;

    logic [7:0] q_o   [4];
    logic [7:0] qb_o  [4];
    logic [7:0] inv_o [4];
    logic [1:0] cnt_o [4];

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] mq   [4];
    logic [7:0] minv [4];
    int         mcnt [4];

    for (genvar p = 0; p < 4; p++) begin : g_dut
        sr_reg_bank #(
            .WIDTH       (8),
            .CNT_W       (2),
            .SR11_POLICY (p),
            .RESET_VAL   (RV)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .en          (en),
            .mode        (mode),
            .S           (s_in),
            .R           (r_in),
            .clr_invalid (clr),
            .Q           (q_o[p]),
            .Q_bar       (qb_o[p]),
            .invalid     (inv_o[p]),
            .invalid_cnt (cnt_o[p])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic bit_next(int pol, int m, logic q, logic s, logic r);
        if (m == 2) return s;
        if (m == 3) return s ? !q : q;
        if (s && !r) return 1'b1;
        if (!s && r) return 1'b0;
        if (!s && !r) return q;
        if (m == 1) return !q;
        case (pol)
            1: return 1'b1;
            2: return 1'b0;
            3: return !q;
            default: return q;
        endcase
    endfunction

    task automatic drive(input logic rst, input logic e, input logic [1:0] m,
                         input logic [7:0] s, input logic [7:0] r, input logic c);
        exp_t       x;
        logic [7:0] illv;
        @(negedge clk);
        reset = rst;
        en    = e;
        mode  = m;
        s_in  = s;
        r_in  = r;
        clr   = c;
        illv  = (e && m == 2'd0) ? (s & r) : 8'h00;
        for (int p = 0; p < 4; p++) begin
            if (rst) begin
                mq[p]   = RV;
                minv[p] = 8'h00;
                mcnt[p] = 0;
            end else begin
                if (e) begin
                    for (int i = 0; i < 8; i++)
                        mq[p][i] = bit_next(p, int'(m), mq[p][i], s[i], r[i]);
                end
                if (illv != 8'h00) begin
                    minv[p] = c ? illv : (minv[p] | illv);
                    mcnt[p] = c ? 1 : ((mcnt[p] >= 3) ? 3 : mcnt[p] + 1);
                end else if (c) begin
                    minv[p] = 8'h00;
                    mcnt[p] = 0;
                end
            end
            x.q[p]   = mq[p];
            x.inv[p] = minv[p];
            x.cnt[p] = 2'(mcnt[p]);
        end
        sb.push_back(x);
    endtask

    task automatic check8(input string nm, input int p, input logic [7:0] act,
                          input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s pol=%0d actual=%h required=%h", nm, p, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int p = 0; p < 4; p++) begin
                    check8("Q", p, q_o[p], e.q[p]);
                    check8("Q_bar", p, qb_o[p], ~e.q[p]);
                    check8("invalid", p, inv_o[p], e.inv[p]);
                    check8("invalid_cnt", p, {6'b0, cnt_o[p]}, {6'b0, e.cnt[p]});
                end
            end
        end
    end

    initial begin : stim
        reset = 1'b1;
        en    = 1'b0;
        mode  = 2'd0;
        s_in  = 8'h00;
        r_in  = 8'h00;
        clr   = 1'b0;
        for (int p = 0; p < 4; p++) begin
            mq[p]   = RV;
            minv[p] = 8'h00;
            mcnt[p] = 0;
        end

        drive(1, 0, 2'd0, 8'h00, 8'h00, 0);
        drive(0, 1, 2'd0, 8'h0F, 8'h00, 0);
        drive(0, 1, 2'd0, 8'h00, 8'h03, 0);
        drive(0, 1, 2'd2, 8'h0F, 8'h00, 0);
        drive(0, 1, 2'd0, 8'hFF, 8'hFF, 0);
        drive(1, 1, 2'd2, 8'h00, 8'h00, 0);
        drive(0, 1, 2'd2, 8'h00, 8'h00, 0);
        repeat (3) drive(0, 1, 2'd1, 8'hFF, 8'hFF, 0);
        repeat (5) drive(0, 1, 2'd0, 8'h01, 8'h01, 0);
        drive(0, 1, 2'd0, 8'h01, 8'h01, 1);
        drive(0, 0, 2'd2, 8'hFF, 8'h00, 0);
        drive(0, 0, 2'd0, 8'h00, 8'h00, 1);
        drive(0, 1, 2'd3, 8'hFF, 8'h00, 0);
        drive(0, 1, 2'd3, 8'h3C, 8'h00, 0);
        drive(1, 1, 2'd3, 8'hFF, 8'h00, 0);
        drive(0, 1, 2'd3, 8'h81, 8'h00, 0);

        for (int k = 0; k < 600; k++) begin
            logic [7:0] s;
            logic [7:0] r;
            s = 8'($urandom);
            r = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = s;
            drive(logic'($urandom_range(0, 39) == 0),
                  logic'($urandom_range(0, 4) != 0),
                  2'($urandom),
                  s, r,
                  logic'($urandom_range(0, 9) == 0));
        end

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
